// File: rtl/key_db_scan_pkg.sv
// Shared definitions for the key debounce scanner: per-key FSM state encoding
// and the counter-width helper used by every channel.
package key_db_scan_pkg;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_DB_PRS = 2'd1,
        KS_HELD   = 2'd2,
        KS_DB_REL = 2'd3
    } key_fsm_e;

    // Width of a counter that must be able to reach max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/key_db_scan_if.sv
// Key bus between the button pins, the debounce scanner and the control logic.
// The scanner uses the slave view; the control/board side uses master.
interface key_db_scan_if #(
    parameter int KEY_NUM = 2
);

    logic [KEY_NUM-1:0] key_pin;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;

    modport master (
        output key_pin,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_pin,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );

endinterface

// File: rtl/key_db_ch.sv
// One debounce channel: 2-FF synchroniser, 4-state debounce FSM, debounce and
// long-press counters, and registered level/pulse outputs for a single key.
module key_db_ch
    import key_db_scan_pkg::*;
#(
    parameter int DB_CNT   = 20*1000*20-1,
    parameter int LONG_CNT = 20*1000*1000-1,
    parameter int ACT_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_pin,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DW = cnt_width(DB_CNT);
    localparam int LW = cnt_width(LONG_CNT);
    localparam logic [DW-1:0] DB_MAX   = DW'(DB_CNT);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CNT);
    localparam logic IDLE_LVL = (ACT_LOW != 0);

    logic     sync_a;
    logic     sync_b;
    logic     act;

    key_fsm_e fsm_q,      fsm_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic     lfired_q,   lfired_d;
    logic     level_q,    level_d;
    logic     press_q,    press_d;
    logic     release_q,  release_d;
    logic     long_q,     long_d;

    // Synchroniser resets to the released pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= IDLE_LVL;
            sync_b <= IDLE_LVL;
        end else begin
            // NOTE: non-blocking so sync_b takes the old sync_a, giving two real flop stages.
            sync_a <= key_pin;
            sync_b <= sync_a;
        end
    end

    assign act = sync_b ^ IDLE_LVL;

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path infers a latch.
        fsm_d     = fsm_q;
        dcnt_d    = dcnt_q;
        lcnt_d    = lcnt_q;
        lfired_d  = lfired_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        unique case (fsm_q)
            KS_IDLE: begin
                if (act) begin
                    fsm_d  = KS_DB_PRS;
                    dcnt_d = '0;
                end
            end
            KS_DB_PRS: begin
                if (!act) begin
                    fsm_d  = KS_IDLE;
                    dcnt_d = '0;
                end else if (dcnt_q == DB_MAX) begin
                    fsm_d    = KS_HELD;
                    press_d  = 1'b1;
                    level_d  = 1'b1;
                    lcnt_d   = '0;
                    lfired_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            KS_HELD: begin
                if (!act) begin
                    fsm_d  = KS_DB_REL;
                    dcnt_d = '0;
                end else if (lcnt_q == LONG_MAX && !lfired_q) begin
                    long_d   = 1'b1;
                    lfired_d = 1'b1;
                end else if (lcnt_q != LONG_MAX) begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            KS_DB_REL: begin
                // A bounce back to pressed keeps lcnt/lfired, so one press never yields two long pulses.
                if (act) begin
                    fsm_d  = KS_HELD;
                    dcnt_d = '0;
                end else if (dcnt_q == DB_MAX) begin
                    fsm_d     = KS_IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: fsm_d = KS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q     <= KS_IDLE;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            lfired_q  <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            dcnt_q    <= dcnt_d;
            lcnt_q    <= lcnt_d;
            lfired_q  <= lfired_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign key_state   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_db_scan.sv
// Debounced push-button scanner: KEY_NUM independent channels publishing a clean
// level plus press, release and long-press pulses on the key bus.
module key_db_scan #(
    parameter int DB_CNT   = 20*1000*20-1,
    parameter int LONG_CNT = 20*1000*1000-1,
    parameter int KEY_NUM  = 2,
    parameter int ACT_LOW  = 1
) (
    input  logic          clk,
    input  logic          rst,
    key_db_scan_if.slave  bus
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_db_ch #(
            .DB_CNT   (DB_CNT),
            .LONG_CNT (LONG_CNT),
            .ACT_LOW  (ACT_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_pin     (bus.key_pin[i]),
            .key_state   (bus.key_state[i]),
            .key_press   (bus.key_press[i]),
            .key_release (bus.key_release[i]),
            .key_long    (bus.key_long[i])
        );
    end

endmodule

// File: tb/tb_key_db_scan.sv
// Bench for key_db_scan: an active-low and an active-high instance driven with
// mirrored pins, both checked every cycle against a run-length debounce model.
`timescale 1ns/1ps
module tb_key_db_scan;

    localparam int DB_CNT   = 7;
    localparam int LONG_CNT = 31;
    localparam int KEY_NUM  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    key_db_scan_if #(.KEY_NUM(KEY_NUM)) bus_a ();
    key_db_scan_if #(.KEY_NUM(KEY_NUM)) bus_b ();

    assign bus_b.key_pin = ~bus_a.key_pin;

    key_db_scan #(.DB_CNT(DB_CNT), .LONG_CNT(LONG_CNT), .KEY_NUM(KEY_NUM), .ACT_LOW(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    key_db_scan #(.DB_CNT(DB_CNT), .LONG_CNT(LONG_CNT), .KEY_NUM(KEY_NUM), .ACT_LOW(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #25 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: debounced level flips after DB_CNT+2 consecutive edges of a differing
    // synchronised level (pin seen 2 edges late); long fires on the (LONG_CNT+1)th
    // continuously-held edge after the press.
    logic [1:0] m_deb, m_h1, m_h2, m_prev, m_fired;
    logic [1:0] exp_press, exp_release, exp_long;
    int         m_run [2];
    int         m_hc  [2];
    int         n_press [2];
    int         n_release [2];
    int         n_long [2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_deb = '0; m_h1 = '0; m_h2 = '0; m_prev = '0; m_fired = '0;
        exp_press = '0; exp_release = '0; exp_long = '0;
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0;
            m_hc[k]  = 0;
        end
    endtask

    task automatic model_tick();
        logic [1:0] a;
        a    = m_h2;
        m_h2 = m_h1;
        m_h1 = ~bus_a.key_pin;
        exp_press = '0; exp_release = '0; exp_long = '0;
        for (int k = 0; k < 2; k++) begin
            if (a[k] != m_deb[k]) begin
                m_run[k]++;
                if (m_run[k] == DB_CNT + 2) begin
                    m_deb[k] = a[k];
                    m_run[k] = 0;
                    if (a[k]) begin
                        exp_press[k] = 1'b1;
                        m_hc[k]      = 0;
                        m_fired[k]   = 1'b0;
                    end else begin
                        exp_release[k] = 1'b1;
                    end
                end
            end else begin
                m_run[k] = 0;
                if (a[k] && m_prev[k] && !m_fired[k]) begin
                    m_hc[k]++;
                    if (m_hc[k] == LONG_CNT + 1) begin
                        exp_long[k]  = 1'b1;
                        m_fired[k]   = 1'b1;
                    end
                end
            end
        end
        m_prev = a;
    endtask

    task automatic compare_all();
        check("A key_state",   32'(bus_a.key_state),   32'(m_deb));
        check("A key_press",   32'(bus_a.key_press),   32'(exp_press));
        check("A key_release", 32'(bus_a.key_release), 32'(exp_release));
        check("A key_long",    32'(bus_a.key_long),    32'(exp_long));
        check("B key_state",   32'(bus_b.key_state),   32'(m_deb));
        check("B key_press",   32'(bus_b.key_press),   32'(exp_press));
        check("B key_release", 32'(bus_b.key_release), 32'(exp_release));
        check("B key_long",    32'(bus_b.key_long),    32'(exp_long));
        check("A press&release overlap", 32'(bus_a.key_press & bus_a.key_release), 32'd0);
        for (int k = 0; k < 2; k++) begin
            n_press[k]   += int'(bus_a.key_press[k]);
            n_release[k] += int'(bus_a.key_release[k]);
            n_long[k]    += int'(bus_a.key_long[k]);
        end
    endtask

    // Advance n clock edges; model updates on each edge, outputs compared mid-cycle.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_tick();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " A outs"}, 32'({bus_a.key_state, bus_a.key_press, bus_a.key_release, bus_a.key_long}), 32'd0);
        check({name, " B outs"}, 32'({bus_b.key_state, bus_b.key_press, bus_b.key_release, bus_b.key_long}), 32'd0);
    endtask

    int p0, r0, l0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            n_press[k] = 0; n_release[k] = 0; n_long[k] = 0;
        end
        bus_a.key_pin = 2'b11;
        model_reset();
        #60;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        step(3);

        // Test 1: clean press, long press, release
        bus_a.key_pin[0] = 1'b0;
        step(10);
        check("t1 press before edge 11", 32'(bus_a.key_press), 32'd0);
        check("t1 state before edge 11", 32'(bus_a.key_state), 32'd0);
        step(1);
        check("t1 press at edge 11",       32'(bus_a.key_press), 32'h1);
        check("t1 model press at edge 11", 32'(exp_press),       32'h1);
        check("t1 state at edge 11",       32'(bus_a.key_state), 32'h1);
        step(1);
        check("t1 press one cycle only", 32'(bus_a.key_press), 32'd0);
        step(30);
        check("t1 long before edge 43", 32'(bus_a.key_long), 32'd0);
        step(1);
        check("t1 long at edge 43",       32'(bus_a.key_long), 32'h1);
        check("t1 model long at edge 43", 32'(exp_long),       32'h1);
        step(7);
        bus_a.key_pin[0] = 1'b1;
        step(10);
        check("t1 release before edge 11", 32'(bus_a.key_release), 32'd0);
        step(1);
        check("t1 release at edge 11", 32'(bus_a.key_release), 32'h1);
        step(1);
        check("t1 state after release", 32'(bus_a.key_state), 32'd0);

        // Test 2: bounce rejection
        p0 = n_press[0]; r0 = n_release[0];
        bus_a.key_pin[0] = 1'b0; step(5);
        bus_a.key_pin[0] = 1'b1; step(3);
        bus_a.key_pin[0] = 1'b0; step(6);
        bus_a.key_pin[0] = 1'b1; step(15);
        check("t2 no press pulse",   32'(n_press[0] - p0),   32'd0);
        check("t2 no release pulse", 32'(n_release[0] - r0), 32'd0);
        check("t2 state stays 0",    32'(bus_a.key_state),   32'd0);

        // Test 3: release bounces before and after the long press
        p0 = n_press[0]; r0 = n_release[0]; l0 = n_long[0];
        bus_a.key_pin[0] = 1'b0; step(21);
        bus_a.key_pin[0] = 1'b1; step(4);
        bus_a.key_pin[0] = 1'b0; step(60);
        check("t3 long after first bounce", 32'(n_long[0] - l0), 32'd1);
        bus_a.key_pin[0] = 1'b1; step(4);
        bus_a.key_pin[0] = 1'b0; step(40);
        check("t3 no release on bounce", 32'(n_release[0] - r0), 32'd0);
        check("t3 still pressed",        32'(bus_a.key_state),   32'h1);
        bus_a.key_pin[0] = 1'b1; step(15);
        check("t3 one press",   32'(n_press[0] - p0),   32'd1);
        check("t3 one release", 32'(n_release[0] - r0), 32'd1);
        check("t3 one long",    32'(n_long[0] - l0),    32'd1);

        // Test 4: two keys together, then key1 released alone
        bus_a.key_pin = 2'b00;
        step(11);
        check("t4 simultaneous press", 32'(bus_a.key_press), 32'h3);
        step(20);
        bus_a.key_pin[1] = 1'b1;
        step(11);
        check("t4 key1 release only", 32'(bus_a.key_release), 32'h2);
        check("t4 key0 still held",   32'(bus_a.key_state),   32'h1);
        step(1);
        bus_a.key_pin[0] = 1'b1;
        step(12);
        check("t4 both released", 32'(bus_a.key_state), 32'd0);

        // Test 5: async reset mid-DB_PRS and mid-HELD
        bus_a.key_pin[0] = 1'b0;
        step(5);
        #5 rst = 1'b0;
        #1 check_all_zero("t5 reset mid-debounce");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(10);
        check("t5 no early press", 32'(bus_a.key_press), 32'd0);
        step(1);
        check("t5 fresh press at edge 11", 32'(bus_a.key_press), 32'h1);
        step(5);
        #5 rst = 1'b0;
        #1 check_all_zero("t5 reset mid-hold");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(10);
        check("t5 held key no early press", 32'(bus_a.key_press), 32'd0);
        step(1);
        check("t5 held key fresh press", 32'(bus_a.key_press), 32'h1);
        check("t5 B fresh press",        32'(bus_b.key_press), 32'h1);
        bus_a.key_pin[0] = 1'b1;
        step(15);
        check("t5 final state", 32'(bus_a.key_state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
